// File: rtl/bus_arb_pkg.sv
// Shared definitions for the four-slot system bus arbiter: state encoding,
// slot indices and slot-vector helpers.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DEAD  = 2'd2
  } arb_state_e;

  localparam int ARB_SLOTS = 4;

  localparam logic [1:0] SLOT_CPU0 = 2'd0;
  localparam logic [1:0] SLOT_CPU1 = 2'd1;
  localparam logic [1:0] SLOT_MEM  = 2'd2;
  localparam logic [1:0] SLOT_IOB  = 2'd3;

  // Slot vectors run [1:4], so slot index 0 is the leftmost bit.
  function automatic logic [1:4] slot_onehot(input logic [1:0] idx);
    logic [1:4] oh;
    case (idx)
      2'd0:    oh = 4'b1000;
      2'd1:    oh = 4'b0100;
      2'd2:    oh = 4'b0010;
      2'd3:    oh = 4'b0001;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  function automatic logic slot_bit(input logic [1:4] v, input logic [1:0] idx);
    return |(v & slot_onehot(idx));
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector over four request lines; the scan
// starts at last+1 and wraps, so the previous winner has lowest priority.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [1:4] zg,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand_s;
  logic       hit_s;

  // Walk the four candidates in priority order and keep the first requester.
  always_comb begin
    valid  = 1'b0;
    idx    = last;
    cand_s = last;
    hit_s  = 1'b0;
    for (int k = 1; k <= ARB_SLOTS; k++) begin
      cand_s = last + k[1:0];
      hit_s  = !valid && slot_bit(zg, cand_s);
      idx    = hit_s ? cand_s : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered one-hot grants and a dead period
// between owners. Define BUS_ARB_TIMEOUT_EN to build the grant watchdog.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_TICKS = 8'd200,
  parameter logic [1:0] DEAD_CYCLES   = 2'd1
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [1:4] zg,
  input  logic [1:4] zz,
  output logic [1:4] zw,
  output logic       busy,
  output logic [1:0] owner,
  output logic       tmo,
  output logic       tmo_err,
  input  logic       tmo_clr
);

  arb_state_e state_r, state_nxt_s;
  logic [1:4] zw_r, zw_nxt_s;
  logic       busy_r;
  logic [1:0] owner_r, owner_nxt_s;
  logic [1:0] last_r, last_nxt_s;
  logic [1:0] dcnt_r, dcnt_nxt_s;
  logic       pick_valid_s;
  logic [1:0] pick_idx_s;
  logic       release_s;
  logic       timeout_s;

  rr_pick4 u_pick (
    .zg    (zg),
    .last  (last_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // An explicit release and a dropped request in the same cycle are one event.
  assign release_s = slot_bit(zz, owner_r) | ~slot_bit(zg, owner_r);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] tcnt_r, tcnt_nxt_s;
  logic       tmo_r, tmo_err_r;

  assign tcnt_nxt_s = (state_r == ARB_GRANT) ? tcnt_r + 8'd1 : 8'd0;
  assign timeout_s  = (state_r == ARB_GRANT) && !release_s &&
                      (tcnt_r == TIMEOUT_TICKS - 8'd1);

  // Watchdog counter and alarm flags; a new timeout beats a clear request.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      tcnt_r    <= 8'd0;
      tmo_r     <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      tcnt_r    <= tcnt_nxt_s;
      tmo_r     <= timeout_s;
      tmo_err_r <= timeout_s | (tmo_err_r & ~tmo_clr);
    end
  end

  assign tmo     = tmo_r;
  assign tmo_err = tmo_err_r;
`else
  logic [8:0] unused_cfg_s;

  assign unused_cfg_s = {TIMEOUT_TICKS, tmo_clr};
  assign timeout_s    = 1'b0;
  assign tmo          = 1'b0;
  assign tmo_err      = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/GRANT/DEAD sequencer.
  always_comb begin
    state_nxt_s = state_r;
    zw_nxt_s    = zw_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    dcnt_nxt_s  = dcnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ARB_GRANT;
          zw_nxt_s    = slot_onehot(pick_idx_s);
          owner_nxt_s = pick_idx_s;
          last_nxt_s  = pick_idx_s;
        end else begin
          zw_nxt_s = 4'b0000;
        end
      end
      ARB_GRANT: begin
        if (release_s || timeout_s) begin
          state_nxt_s = ARB_DEAD;
          zw_nxt_s    = 4'b0000;
          dcnt_nxt_s  = 2'd0;
        end else begin
          zw_nxt_s = slot_onehot(owner_r);
        end
      end
      ARB_DEAD: begin
        zw_nxt_s = 4'b0000;
        if (dcnt_r >= DEAD_CYCLES - 2'd1) begin
          state_nxt_s = ARB_IDLE;
          dcnt_nxt_s  = 2'd0;
        end else begin
          dcnt_nxt_s = dcnt_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
        zw_nxt_s    = 4'b0000;
        dcnt_nxt_s  = 2'd0;
      end
    endcase
  end

  // State and output registers; reset drops any grant with no dead period.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      zw_r    <= 4'b0000;
      busy_r  <= 1'b0;
      owner_r <= 2'd0;
      last_r  <= 2'd3;
      dcnt_r  <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      zw_r    <= zw_nxt_s;
      busy_r  <= (state_nxt_s == ARB_GRANT);
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
      dcnt_r  <= dcnt_nxt_s;
    end
  end

  assign zw    = zw_r;
  assign busy  = busy_r;
  assign owner = owner_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each cycle's expected outputs are queued
// as stimulus is driven and compared on the following falling edge.
module tb_bus_arbiter;

  typedef struct packed {
    logic [1:4] zw;
    logic       busy;
    logic [1:0] owner;
    logic       tmo;
    logic       tmo_err;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:4] zg      = 4'b0000;
  logic [1:4] zz      = 4'b0000;
  logic       tmo_clr = 1'b0;
  logic [1:4] zw;
  logic       busy;
  logic [1:0] owner;
  logic       tmo;
  logic       tmo_err;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bus_arbiter #(.TIMEOUT_TICKS(8'd10), .DEAD_CYCLES(2'd1)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .zg      (zg),
    .zz      (zz),
    .zw      (zw),
    .busy    (busy),
    .owner   (owner),
    .tmo     (tmo),
    .tmo_err (tmo_err),
    .tmo_clr (tmo_clr)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic exp_t mk(logic [1:4] w, logic b, logic [1:0] o, logic t, logic e);
    mk = {w, b, o, t, e};
  endfunction

  function automatic logic [1:4] oh(int s);
    logic [1:4] base;
    base = 4'b1000;
    return base >> s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; zg = 4'b0000; zz = 4'b0000; tmo_clr = 1'b0;
    @(posedge clk_sys); @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, obs;
    for (int c = 0; c < 3; c++) begin
      rst_n = (c < 2) ? 1'b0 : 1'b1;
      zg    = (c < 2) ? 4'b1111 : 4'b0000;
      zz    = 4'b0000;
      sb.push_back(mk(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e, obs;
    for (int c = 0; c < 8; c++) begin
      zg = (c < 6) ? 4'b1000 : 4'b0000;
      zz = (c == 5) ? 4'b1000 : 4'b0000;
      sb.push_back((c < 5) ? mk(4'b1000, 1'b1, 2'd0, 1'b0, 1'b0)
                           : mk(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL basic c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

  // All four request; each owner holds three cycles, then a two-cycle gap.
  task automatic test_round_robin();
    exp_t e, obs;
    int   p, slot;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      p    = c % 5;
      slot = (c / 5) % 4;
      zg   = 4'b1111;
      zz   = (p == 3) ? oh(slot) : 4'b0000;
      sb.push_back((p < 3) ? mk(oh(slot), 1'b1, slot[1:0], 1'b0, 1'b0)
                           : mk(4'b0000, 1'b0, slot[1:0], 1'b0, 1'b0));
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL round_robin c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

  task automatic test_non_owner();
    exp_t e, obs;
    logic [1:4] zg_t [6] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b0000};
    logic [1:4] zz_t [6] = '{4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      zg = zg_t[c];
      zz = zz_t[c];
      sb.push_back((c < 4) ? mk(4'b0100, 1'b1, 2'd1, 1'b0, 1'b0)
                           : mk(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0));
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL non_owner c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

  // Joint release gives a single dead cycle; a re-requesting owner then loses.
  task automatic test_simul_release();
    exp_t e, obs;
    logic [1:4] zg_t [10] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010,
                              4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    logic [1:4] zz_t [10] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                              4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    exp_t ex_t [10] = '{mk(4'b0010, 1'b1, 2'd2, 1'b0, 1'b0), mk(4'b0010, 1'b1, 2'd2, 1'b0, 1'b0),
                        mk(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0), mk(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0),
                        mk(4'b0010, 1'b1, 2'd2, 1'b0, 1'b0), mk(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0),
                        mk(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0), mk(4'b0001, 1'b1, 2'd3, 1'b0, 1'b0),
                        mk(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0), mk(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0)};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      zg = zg_t[c];
      zz = zz_t[c];
      sb.push_back(ex_t[c]);
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL simul_release c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  // Round 0: timeout then later clear; round 1: release on the last tick
  // wins; round 2: timeout and clear on the same cycle keeps the flag.
  task automatic test_timeout();
    exp_t e, obs;
    logic t, er;
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int r = 0; r < 13; r++) begin
        zg      = (r <= 10) ? 4'b0010 : 4'b0000;
        zz      = (rnd == 1 && r == 10) ? 4'b0010 : 4'b0000;
        tmo_clr = (rnd == 0 && r == 12) || (rnd == 2 && (r == 10 || r == 11));
        t  = (r == 10) && (rnd != 1);
        er = ((r == 10) && (rnd != 1)) || ((r == 11) && (rnd == 0));
        sb.push_back((r < 10) ? mk(4'b0010, 1'b1, 2'd2, 1'b0, 1'b0)
                              : mk(4'b0000, 1'b0, 2'd2, t, er));
        @(posedge clk_sys); @(negedge clk_sys);
        e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL timeout rnd=%0d r=%0d actual=%b required=%b", rnd, r, obs, e);
        end
      end
    end
    tmo_clr = 1'b0;
  endtask
`else
  // Without the watchdog a grant outlives TIMEOUT_TICKS and no alarm appears.
  task automatic test_hold();
    exp_t e, obs;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      zg      = (c < 15) ? 4'b0010 : 4'b0000;
      zz      = 4'b0000;
      tmo_clr = c[0];
      sb.push_back((c < 15) ? mk(4'b0010, 1'b1, 2'd2, 1'b0, 1'b0)
                            : mk(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0));
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL hold c=%0d actual=%b required=%b", c, obs, e);
      end
    end
    tmo_clr = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e, obs;
    exp_t ex_t [6] = '{mk(4'b0100, 1'b1, 2'd1, 1'b0, 1'b0), mk(4'b0100, 1'b1, 2'd1, 1'b0, 1'b0),
                       mk(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0), mk(4'b0100, 1'b1, 2'd1, 1'b0, 1'b0),
                       mk(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0), mk(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0)};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      rst_n = (c == 2) ? 1'b0 : 1'b1;
      zg    = (c < 4) ? 4'b0100 : 4'b0000;
      zz    = 4'b0000;
      sb.push_back(ex_t[c]);
      @(posedge clk_sys); @(negedge clk_sys);
      e = sb.pop_front(); obs = {zw, busy, owner, tmo, tmo_err}; checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid c=%0d actual=%b required=%b", c, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_non_owner();
    test_simul_release();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
